// File: rtl/ram_dma_if.sv
// Bundle between ram_dma and its neighbours: engine control from the CPU side,
// CPU pass-through port, and the single-port RAM port.
interface ram_dma_if #(
  parameter int address_width = 10,
  parameter int data_width    = 8
) ();
  // start is a one-cycle request honoured only while busy=0; busy then stays
  // high until the cycle after done, which pulses on the final busy cycle.
  logic                     start;
  logic                     mode;
  logic [address_width-1:0] src_addr;
  logic [address_width-1:0] dst_addr;
  logic [address_width:0]   length;
  logic [data_width-1:0]    fill_data;
  logic                     busy;
  logic                     done;
  logic [address_width-1:0] cpu_addr;
  logic                     cpu_wren;
  logic [data_width-1:0]    cpu_data;
  logic [data_width-1:0]    cpu_q;
  logic [address_width-1:0] ram_address;
  logic                     ram_wren;
  logic [data_width-1:0]    ram_data;
  logic [data_width-1:0]    ram_q;

  modport master (
    output start, mode, src_addr, dst_addr, length, fill_data,
    output cpu_addr, cpu_wren, cpu_data, ram_q,
    input  busy, done, cpu_q, ram_address, ram_wren, ram_data
  );

  modport slave (
    input  start, mode, src_addr, dst_addr, length, fill_data,
    input  cpu_addr, cpu_wren, cpu_data, ram_q,
    output busy, done, cpu_q, ram_address, ram_wren, ram_data
  );
endinterface

// File: rtl/ram_dma.sv
// Fill/copy sequencer owning the single-port RAM port; passes CPU accesses
// through while idle.
module ram_dma #(
  parameter int address_width = 10,
  parameter int data_width    = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  ram_dma_if.slave   bus,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FILL = 3'd1;
  localparam logic [2:0] CRD  = 3'd2;
  localparam logic [2:0] CWR  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [address_width:0] cnt_one = 1;

  logic [2:0]               state;
  logic [address_width:0]   count;
  logic [address_width:0]   len_q;
  logic [address_width-1:0] src_q;
  logic [address_width-1:0] dst_q;
  logic [data_width-1:0]    fill_q;
  logic [address_width-1:0] offset;
  logic                     last;

  assign offset = count[address_width-1:0];
  // count is one bit wider than the address so a full-RAM length terminates.
  assign last   = (count == len_q - cnt_one);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      len_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q  <= bus.length;
            src_q  <= bus.src_addr;
            dst_q  <= bus.dst_addr;
            fill_q <= bus.fill_data;
            count  <= '0;
            if (bus.length == '0) state <= DONE;
            else if (bus.mode)    state <= CRD;
            else                  state <= FILL;
          end
        end
        FILL: begin
          count <= count + cnt_one;
          if (last) state <= DONE;
        end
        CRD: state <= CWR;
        CWR: begin
          count <= count + cnt_one;
          state <= last ? DONE : CRD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Engine writes are gated by reset so an abort never lands one more word.
  always_comb begin
    bus.ram_address = bus.cpu_addr;
    bus.ram_wren    = bus.cpu_wren;
    bus.ram_data    = bus.cpu_data;
    case (state)
      IDLE: ;
      FILL: begin
        bus.ram_address = dst_q + offset;
        bus.ram_wren    = reset_n;
        bus.ram_data    = fill_q;
      end
      CRD: begin
        bus.ram_address = src_q + offset;
        bus.ram_wren    = 1'b0;
      end
      CWR: begin
        bus.ram_address = dst_q + offset;
        bus.ram_wren    = reset_n;
        bus.ram_data    = bus.ram_q;
      end
      default: bus.ram_wren = 1'b0;
    endcase
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.cpu_q = bus.ram_q;
  assign dbg_state = state;

endmodule
